fifo_stack_n: RTL and testbench
===============================

Name: fifo_stack_n

Overview:
Parametrised multi-bit successor to the 1-bit fifo_stack_u buffer. It stores DATA_WIDTH-bit words in a DEPTH-entry circular buffer, using the same save/pop/busy request style. It sits between the USB3300 byte parser and downstream consumers (UART/serial packer), absorbing bursts. It adds occupancy count, almost-full, sticky error flags and a compile-time LIFO mode.

Parameters:
DATA_WIDTH, 8, word width in bits (>=1)
DEPTH, 16, number of entries; power of two, >=2
ADDR_WIDTH, 4, log2(DEPTH); must match DEPTH
AF_LEVEL, 12, almost_full asserts when count >= AF_LEVEL (1..DEPTH)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset; 0 = reset asserted
I_DATA  input  DATA_WIDTH  write data, sampled with save
save  input  1  write request, level-sampled at clock edge
pop  input  1  read request, level-sampled at clock edge
O_DATA  output  DATA_WIDTH  registered read data, held until next accepted pop
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_LEVEL
busy  output  1  1 = request ignored this edge
count  output  ADDR_WIDTH+1  current occupancy 0..DEPTH
overflow  output  1  sticky: save seen while full
underflow  output  1  sticky: pop seen while empty

Behaviour:
- Reset (reset=0, async): O_DATA=0, count=0, empty=1, full=0, almost_full=0, busy=0, overflow=0, underflow=0, rd_ptr=wr_ptr=0, state=IDLE. Memory contents are not cleared. Reset mid-operation discards all data and any pending request.
- FSM has two states, IDLE and BUSY. busy = (state == BUSY).
- IDLE: at an edge with save or pop accepted, perform the operation and go to BUSY. Otherwise stay in IDLE.
- BUSY: unconditionally return to IDLE on the next edge. Requests sampled while busy=1 are ignored and do not set error flags. Maximum throughput is one operation per 2 cycles.
- Save accepted (IDLE, save=1, pop=0, full=0): mem[wr_ptr]<=I_DATA, wr_ptr++ (mod DEPTH), count++.
- Pop accepted (IDLE, pop=1, save=0, empty=0): O_DATA<=mem[rd_ptr], rd_ptr++ (mod DEPTH), count--. O_DATA is valid the cycle after the accepting edge.
- Simultaneous save and pop in IDLE:
  - If not empty: both are performed in one edge. O_DATA gets the oldest word, the new word is written, count is unchanged. This also applies when full.
  - If empty: only the save is performed. underflow is set. O_DATA is unchanged.
- Save while full (IDLE, pop=0): no write, overflow<=1, still enter BUSY. Pop while empty (IDLE, save=0): O_DATA unchanged, underflow<=1, still enter BUSY.
- full, empty and almost_full are combinational decodes of the registered count. They update the cycle after the accepting edge.
- Pointer wrap is natural modulo DEPTH. count carries the full/empty distinction.
- Sticky flags clear only on reset.

Optional Feature:
Macro FIFO_STACK_N_LIFO_EN.
- Defined: the block is a stack. Save writes mem[sp] and sp++. Pop reads mem[sp-1] and sp--.
- Simultaneous save+pop when not empty: O_DATA<=top, top entry replaced by I_DATA, sp unchanged. When empty, it is treated as save only plus underflow.
- All flags, busy timing and error rules are identical to FIFO mode.
- Undefined: FIFO behaviour as above. No stack logic is synthesised.

Test Plan:
(All with DATA_WIDTH=8, DEPTH=4, AF_LEVEL=3.)
1. Reset, then save 0xA1, 0xB2, 0xC3, respecting busy, then pop x3. Required: O_DATA = 0xA1, 0xB2, 0xC3 in order; count 3->0; empty=1 at end; almost_full=1 only while count=3.
2. Save 4 words (full=1), save 0xFF once more, then pop x4. Required: overflow=1; 0xFF never appears; the 4 original words pop in order. Then save 0x11 and pop again to confirm pointer wrap returns 0x11.
3. Pop on empty FIFO. Required: underflow=1, O_DATA unchanged (0x00), count=0. Then save+pop together on empty with I_DATA=0x5A. Required: count=1 and the next pop yields 0x5A.
4. Hold save=1 continuously with data incrementing every cycle. Required: busy toggles 0/1, only the words sampled while busy=0 are stored, and count increments every 2 cycles.
5. With 2 words stored (0x10, 0x20), drive reset=0 asynchronously between edges while busy=1. Required: all outputs at reset values immediately. After release, a save of 0x33 followed by a pop returns 0x33.
6. With FIFO_STACK_N_LIFO_EN: save 0x01, 0x02, 0x03, then pop x3. Required: O_DATA = 0x03, 0x02, 0x01. Then, with 0x01 stored, do save 0x09 + pop together. Required: O_DATA=0x01, count stays 1, next pop returns 0x09.

Source files
------------

// File: rtl/fifo_stack_n.sv
// Multi-bit request-style FIFO with occupancy, almost-full and sticky error flags.
// Define FIFO_STACK_N_LIFO_EN to build the same block as a stack (LIFO).
module fifo_stack_n #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_LEVEL   = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] I_DATA,
    input  logic                  save,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] O_DATA,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  busy,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_idx;
    logic [ADDR_WIDTH-1:0] rd_idx;
    logic                  idle;
    logic                  do_save;
    logic                  do_pop;

    assign busy        = (state == BUSY);
    assign idle        = (state == IDLE);
    assign full        = (count == (ADDR_WIDTH+1)'(DEPTH));
    assign empty       = (count == '0);
    assign almost_full = (count >= (ADDR_WIDTH+1)'(AF_LEVEL));

    // A save against a full buffer is still taken when a pop frees a slot in the same edge.
    assign do_save = idle && save && (!full || (pop && !empty));
    assign do_pop  = idle && pop && !empty;

`ifdef FIFO_STACK_N_LIFO_EN
    logic [ADDR_WIDTH-1:0] top_idx;

    // count doubles as the stack pointer; save+pop replaces the top in place.
    assign top_idx = count[ADDR_WIDTH-1:0] - 1'b1;

    always_comb begin
        rd_idx = top_idx;
        wr_idx = do_pop ? top_idx : count[ADDR_WIDTH-1:0];
    end
`else
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;

    always_comb begin
        rd_idx = rd_ptr;
        wr_idx = wr_ptr;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_save) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end
`endif

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (do_save) mem[wr_idx] <= I_DATA;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            count     <= '0;
            O_DATA    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (save || pop) state <= BUSY;
                    if (do_pop) O_DATA <= mem[rd_idx];
                    if (do_save && !do_pop)      count <= count + 1'b1;
                    else if (do_pop && !do_save) count <= count - 1'b1;
                    if (save && !pop && full) overflow  <= 1'b1;
                    if (pop && empty)         underflow <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_stack_n.sv
// Randomised and directed bench for fifo_stack_n against a queue-based reference model.
module tb_fifo_stack_n;

    localparam int DW = 8;
    localparam int DP = 4;
    localparam int AW = 2;
    localparam int AF = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] I_DATA;
    logic          save;
    logic          pop;
    logic [DW-1:0] O_DATA;
    logic          full, empty, almost_full, busy, overflow, underflow;
    logic [AW:0]   count;

    int n_chk = 0;
    int n_err = 0;

    // reference model state
    logic [DW-1:0] q[$];
    bit            m_busy, m_ovf, m_unf;
    logic [DW-1:0] m_od;

    fifo_stack_n #(.DATA_WIDTH(DW), .DEPTH(DP), .ADDR_WIDTH(AW), .AF_LEVEL(AF)) dut (
        .clk(clk), .reset(reset), .I_DATA(I_DATA), .save(save), .pop(pop),
        .O_DATA(O_DATA), .full(full), .empty(empty), .almost_full(almost_full),
        .busy(busy), .count(count), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        q.delete();
        m_busy = 0; m_ovf = 0; m_unf = 0; m_od = '0;
    endfunction

    function automatic void model_edge(input bit s, input bit p, input logic [DW-1:0] d);
        if (m_busy) begin
            m_busy = 0;
        end else if (s || p) begin
            m_busy = 1;
            if (s && p) begin
                if (q.size() == 0) begin
                    q.push_back(d);
                    m_unf = 1;
                end else begin
`ifdef FIFO_STACK_N_LIFO_EN
                    m_od = q[q.size()-1];
                    q[q.size()-1] = d;
`else
                    m_od = q.pop_front();
                    q.push_back(d);
`endif
                end
            end else if (s) begin
                if (q.size() == DP) m_ovf = 1;
                else q.push_back(d);
            end else begin
                if (q.size() == 0) m_unf = 1;
`ifdef FIFO_STACK_N_LIFO_EN
                else m_od = q.pop_back();
`else
                else m_od = q.pop_front();
`endif
            end
        end
    endfunction

    task automatic check_all();
        check("count",       32'(count),       32'(q.size()));
        check("full",        32'(full),        32'(q.size() == DP));
        check("empty",       32'(empty),       32'(q.size() == 0));
        check("almost_full", 32'(almost_full), 32'(q.size() >= AF));
        check("busy",        32'(busy),        32'(m_busy));
        check("overflow",    32'(overflow),    32'(m_ovf));
        check("underflow",   32'(underflow),   32'(m_unf));
        check("O_DATA",      32'(O_DATA),      32'(m_od));
    endtask

    // One clock edge with the given request; outputs are compared 1ns after the edge.
    task automatic cyc(input bit s, input bit p, input logic [DW-1:0] d);
        save = s; pop = p; I_DATA = d;
        @(posedge clk);
        model_edge(s, p, d);
        #1;
        check_all();
    endtask

    task automatic op(input bit s, input bit p, input logic [DW-1:0] d);
        cyc(s, p, d);
        cyc(1'b0, 1'b0, '0);
    endtask

    // Asserts reset between edges and checks that outputs clear without a clock.
    task automatic do_reset();
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check_all();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; save = 1'b0; pop = 1'b0; I_DATA = '0;
        model_reset();
        #3;
        check_all();
        @(negedge clk);
        reset = 1'b1;

`ifndef FIFO_STACK_N_LIFO_EN
        // in-order save/pop with almost_full window
        op(1, 0, 8'hA1); op(1, 0, 8'hB2); op(1, 0, 8'hC3);
        check("t1_af3", 32'(almost_full), 32'd1);
        op(0, 1, 8'h00); check("t1_pop0", 32'(O_DATA), 32'hA1);
        check("t1_af2", 32'(almost_full), 32'd0);
        op(0, 1, 8'h00); check("t1_pop1", 32'(O_DATA), 32'hB2);
        op(0, 1, 8'h00); check("t1_pop2", 32'(O_DATA), 32'hC3);
        check("t1_empty", 32'(empty), 32'd1);

        // overflow and pointer wrap
        for (int i = 0; i < 4; i++) op(1, 0, 8'(8'h60 + i));
        check("t2_full", 32'(full), 32'd1);
        op(1, 0, 8'hFF);
        check("t2_ovf", 32'(overflow), 32'd1);
        for (int i = 0; i < 4; i++) begin
            op(0, 1, 8'h00);
            check("t2_pop", 32'(O_DATA), 32'(8'h60 + i));
        end
        op(1, 0, 8'h11); op(0, 1, 8'h00);
        check("t2_wrap", 32'(O_DATA), 32'h11);
        do_reset();

        // underflow, then save+pop on empty
        op(0, 1, 8'h00);
        check("t3_unf", 32'(underflow), 32'd1);
        check("t3_od", 32'(O_DATA), 32'h00);
        op(1, 1, 8'h5A);
        check("t3_cnt", 32'(count), 32'd1);
        check("t3_od2", 32'(O_DATA), 32'h00);
        op(0, 1, 8'h00);
        check("t3_pop", 32'(O_DATA), 32'h5A);

        // save held high: only every other edge is accepted
        for (int i = 0; i < 7; i++) cyc(1, 0, 8'(8'h40 + i));
        cyc(0, 0, 8'h00);
        check("t4_full", 32'(full), 32'd1);
        for (int i = 0; i < 4; i++) begin
            op(0, 1, 8'h00);
            check("t4_pop", 32'(O_DATA), 32'(8'h40 + 2 * i));
        end

        // reset while busy discards stored data
        op(1, 0, 8'h10); op(1, 0, 8'h20);
        cyc(1, 0, 8'h77);
        check("t5_busy", 32'(busy), 32'd1);
        do_reset();
        check("t5_od", 32'(O_DATA), 32'h00);
        op(1, 0, 8'h33); op(0, 1, 8'h00);
        check("t5_pop", 32'(O_DATA), 32'h33);
`else
        // stack order and in-place replace
        op(1, 0, 8'h01); op(1, 0, 8'h02); op(1, 0, 8'h03);
        op(0, 1, 8'h00); check("t6_pop0", 32'(O_DATA), 32'h03);
        op(0, 1, 8'h00); check("t6_pop1", 32'(O_DATA), 32'h02);
        op(0, 1, 8'h00); check("t6_pop2", 32'(O_DATA), 32'h01);
        op(1, 0, 8'h01);
        op(1, 1, 8'h09);
        check("t6_sp_od", 32'(O_DATA), 32'h01);
        check("t6_sp_cnt", 32'(count), 32'd1);
        op(0, 1, 8'h00);
        check("t6_pop3", 32'(O_DATA), 32'h09);
        op(1, 1, 8'h44);
        check("t6_unf", 32'(underflow), 32'd1);
`endif

        // randomised traffic with occasional mid-run reset
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if (i % 151 == 150) do_reset();
            cyc($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45, 8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
